// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle MIPS-subset control FSM with a fixed-latency MDU wait state
// Ports: clk, reset (asynchronous, active-low); op/funct/ALUFlag decode inputs;
//   pcWrite/irWrite/regWrite/memWrite write enables; mduStart/mduOp/mduBusy MDU control;
//   regDst/regSrc/ALUSrc/ALUCtrl/EXTCtrl/NPCCtrl datapath selects; state; instrDone.
module multi_cycle_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int ALU_W       = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             ALUFlag,
    output logic             pcWrite,
    output logic             irWrite,
    output logic             regWrite,
    output logic             memWrite,
    output logic             mduStart,
    output logic             mduOp,
    output logic             mduBusy,
    output logic [1:0]       regDst,
    output logic [1:0]       regSrc,
    output logic             ALUSrc,
    output logic [ALU_W-1:0] ALUCtrl,
    output logic             EXTCtrl,
    output logic [1:0]       NPCCtrl,
    output logic [2:0]       state,
    output logic             instrDone
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MDU    = 3'd5
    } state_t;

    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_LUI = ALU_W'(3);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pc_w, ir_w, rw_w, mw_w, start_w, done_w;

    logic r_type, is_addu, is_subu, is_jr, is_mult, is_div, is_mfhi, is_mflo;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_jump, is_nop;

    assign r_type  = op == 6'b000000;
    assign is_addu = r_type && funct == 6'b100001;
    assign is_subu = r_type && funct == 6'b100011;
    assign is_jr   = r_type && funct == 6'b001000;
    assign is_mult = r_type && funct == 6'b011000;
    assign is_div  = r_type && funct == 6'b011010;
    assign is_mfhi = r_type && funct == 6'b010000;
    assign is_mflo = r_type && funct == 6'b010010;
    assign is_ori  = op == 6'b001101;
    assign is_lui  = op == 6'b001111;
    assign is_lw   = op == 6'b100011;
    assign is_sw   = op == 6'b101011;
    assign is_beq  = op == 6'b000100;
    assign is_j    = op == 6'b000010;
    assign is_jal  = op == 6'b000011;
    assign is_jump = is_j || is_jal || is_jr;
    assign is_nop  = !(is_jump || is_addu || is_subu || is_mult || is_div || is_mfhi || is_mflo ||
                       is_ori || is_lui || is_lw || is_sw || is_beq);

    always_comb begin
        state_d = S_FETCH;
        cnt_d   = '0;
        pc_w    = 1'b0;
        ir_w    = 1'b0;
        rw_w    = 1'b0;
        mw_w    = 1'b0;
        start_w = 1'b0;
        done_w  = 1'b0;
        mduOp   = 1'b0;
        regDst  = 2'd0;
        regSrc  = 2'd0;
        ALUSrc  = 1'b0;
        ALUCtrl = ALU_ADD;
        EXTCtrl = 1'b0;
        NPCCtrl = 2'd0;
        case (state_q)
            S_FETCH: begin
                ir_w    = 1'b1;
                pc_w    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                pc_w    = is_jump;
                NPCCtrl = is_jr ? 2'd3 : is_jump ? 2'd2 : 2'd0;
                rw_w    = is_jal;
                regDst  = is_jal ? 2'd2 : 2'd0;
                regSrc  = is_jal ? 2'd2 : 2'd0;
                done_w  = is_jump || is_nop;
                state_d = (is_jump || is_nop) ? S_FETCH : S_EXE;
            end
            S_EXE: begin
                if (is_beq) begin
                    ALUCtrl = ALU_SUB;
                    pc_w    = ALUFlag;
                    NPCCtrl = 2'd1;
                    done_w  = 1'b1;
                end else if (is_lw || is_sw) begin
                    ALUSrc  = 1'b1;
                    EXTCtrl = 1'b1;
                    state_d = S_MEM;
                end else if (is_mult || is_div) begin
                    start_w = 1'b1;
                    mduOp   = is_div;
                    // Loaded with N-1 so that S_MDU occupies exactly N cycles.
                    cnt_d   = is_div ? 8'(DIV_CYCLES - 1) : 8'(MULT_CYCLES - 1);
                    state_d = S_MDU;
                end else if (!is_nop && !is_jump) begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mw_w    = is_sw;
                done_w  = is_sw;
                state_d = is_lw ? S_WB : S_FETCH;
            end
            S_WB: begin
                rw_w    = 1'b1;
                done_w  = 1'b1;
                regDst  = (is_addu || is_subu || is_mfhi || is_mflo) ? 2'd1 : 2'd0;
                regSrc  = is_lw ? 2'd1 : (is_mfhi || is_mflo) ? 2'd3 : 2'd0;
                ALUSrc  = is_ori || is_lui;
                ALUCtrl = is_ori ? ALU_OR : is_lui ? ALU_LUI : ALU_ADD;
                mduOp   = is_mflo;
            end
            S_MDU: begin
                done_w  = cnt_q == 8'd0;
                cnt_d   = cnt_q == 8'd0 ? 8'd0 : cnt_q - 8'd1;
                state_d = cnt_q == 8'd0 ? S_FETCH : S_MDU;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset forces state to S_FETCH, whose enables must still be masked while reset is low.
    assign pcWrite   = reset && pc_w;
    assign irWrite   = reset && ir_w;
    assign regWrite  = reset && rw_w;
    assign memWrite  = reset && mw_w;
    assign mduStart  = reset && start_w;
    assign instrDone = reset && done_w;
    assign mduBusy   = state_q == S_MDU;
    assign state     = state_q;
endmodule
